// File: rtl/toggle_event_decoder_if.sv
// Pending-event handshake bundle for toggle_event_decoder.
// master: the decoder (offers pending events); slave: the consumer.
interface toggle_event_decoder_if #(
   parameter int PEND_W = 3
);
   logic              evt_valid;
   logic              evt_ready;
   logic [PEND_W-1:0] pend_cnt;

   modport master (
      output evt_valid,
      output pend_cnt,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  pend_cnt,
      output evt_ready
   );
endinterface

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns each level change on a toggle-encoded line
// into a one-cycle pulse, counts events, and buffers them as pending
// credits handed out through a valid/ready handshake with sticky overflow.
// Optional macro TGL_SYNC_EN: inserts a two-flop synchronizer on t_in and
// stretches INIT to three cycles so the baseline comes from settled data.
module toggle_event_decoder #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  t_in,
   input  logic                  clr_ovf,
   toggle_event_decoder_if.master evt,
   output logic                  pulse_o,
   output logic                  level_o,
   output logic [CNT_W-1:0]      evt_count,
   output logic                  ovf
);
   localparam int PEND_W = $clog2(DEPTH + 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state, state_nxt;
   logic [1:0]        init_cnt, init_nxt;
   logic              t_dec;
   logic              tgl;
   logic              acc;
   logic [PEND_W-1:0] pend, pend_nxt;
   logic              ovf_nxt;

`ifdef TGL_SYNC_EN
   localparam int INIT_LEN = 3;
   logic sync1, sync2;

   // Two-flop synchronizer for an asynchronous sending domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= t_in;
         sync2 <= sync1;
      end
   end

   assign t_dec = sync2;
`else
   localparam int INIT_LEN = 1;
   assign t_dec = t_in;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_nxt;
      end
   end

   // Next state: INIT holds for INIT_LEN cycles, then RUN until reset.
   always_comb begin
      state_nxt = state;
      init_nxt  = init_cnt;
      case (state)
         S_INIT: begin
            if (init_cnt == 2'(INIT_LEN - 1)) begin
               state_nxt = S_RUN;
               init_nxt  = '0;
            end else begin
               init_nxt = init_cnt + 2'd1;
            end
         end
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   assign tgl           = (state == S_RUN) && (t_dec != level_o);
   assign evt.evt_valid = (pend != '0);
   assign evt.pend_cnt  = pend;
   assign acc           = evt.evt_valid & evt.evt_ready;

   // Pending credit and overflow update; a toggle and an accept in the
   // same cycle cancel, so that case can never overflow.
   always_comb begin
      pend_nxt = pend;
      ovf_nxt  = ovf;
      if (clr_ovf)
         ovf_nxt = 1'b0;
      if (tgl && !acc) begin
         if (pend < PEND_W'(DEPTH))
            pend_nxt = pend + PEND_W'(1);
         else
            ovf_nxt = 1'b1;
      end else if (!tgl && acc) begin
         pend_nxt = pend - PEND_W'(1);
      end
   end

   // Datapath registers: baseline/level capture, pulse, counters, ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_o   <= 1'b0;
         pulse_o   <= 1'b0;
         evt_count <= '0;
         pend      <= '0;
         ovf       <= 1'b0;
      end else begin
         level_o <= t_dec;
         pulse_o <= tgl;
         if (tgl)
            evt_count <= evt_count + CNT_W'(1);
         pend <= pend_nxt;
         ovf  <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_toggle_event_decoder.sv
// Randomized self-checking bench for toggle_event_decoder (default build),
// with directed prologue following the reset/toggle/overflow/drain/wrap
// scenarios. Small CNT_W so counter wrap is exercised often.
module tb_toggle_event_decoder;
   localparam int CNT_W = 2;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst, t_in, clr_ovf;
   logic             pulse_o, level_o, ovf;
   logic [CNT_W-1:0] evt_count;

   toggle_event_decoder_if #(.PEND_W(PW)) evt_bus ();

   toggle_event_decoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .t_in      (t_in),
      .clr_ovf   (clr_ovf),
      .evt       (evt_bus.master),
      .pulse_o   (pulse_o),
      .level_o   (level_o),
      .evt_count (evt_count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_init, m_level, m_pulse, m_ovf;
   int m_count, m_pend;
   bit tv = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit t, input bit c, input bit rdy);
      bit tgl, acc;
      if (r) begin
         m_init = 1; m_level = 0; m_pulse = 0; m_ovf = 0; m_count = 0; m_pend = 0;
         return;
      end
      tgl = 0;
      acc = (m_pend > 0) && rdy;
      if (!m_init) tgl = (t != m_level);
      m_init  = 0;
      m_level = t;
      m_pulse = tgl;
      if (tgl) m_count = (m_count + 1) % (1 << CNT_W);
      if (c) m_ovf = 0;
      if (tgl && !acc) begin
         if (m_pend < DEPTH) m_pend++;
         else m_ovf = 1;
      end else if (!tgl && acc) begin
         m_pend--;
      end
   endtask

   task automatic step(input bit r, input bit t, input bit c, input bit rdy);
      rst = r; t_in = t; clr_ovf = c; evt_bus.evt_ready = rdy;
      @(posedge clk);
      model_edge(r, t, c, rdy);
      #1;
      check("pulse_o",   int'(pulse_o),           int'(m_pulse));
      check("level_o",   int'(level_o),           int'(m_level));
      check("evt_count", int'(evt_count),         m_count);
      check("pend_cnt",  int'(evt_bus.pend_cnt),  m_pend);
      check("evt_valid", int'(evt_bus.evt_valid), int'(m_pend != 0));
      check("ovf",       int'(ovf),               int'(m_ovf));
   endtask

   initial begin
      rst = 1'b1; t_in = 1'b0; clr_ovf = 1'b0; evt_bus.evt_ready = 1'b0;

      // reset release with t_in high: baseline only, no pulse
      tv = 1;
      step(1, tv, 0, 0); step(1, tv, 0, 0);
      for (int i = 0; i < 5; i++) step(0, tv, 0, 0);
      check("rel_level", int'(level_o), 1);
      check("rel_count", int'(evt_count), 0);

      // isolated toggles, then back-to-back toggles
      tv = ~tv; step(0, tv, 0, 0);
      check("single_pulse", int'(pulse_o), 1);
      for (int i = 0; i < 3; i++) step(0, tv, 0, 0);
      tv = ~tv; step(0, tv, 0, 0);
      step(0, tv, 0, 0);
      check("two_pend", int'(evt_bus.pend_cnt), 2);
      for (int i = 0; i < 3; i++) begin tv = ~tv; step(0, tv, 0, 0); end
      check("b2b_ovf", int'(ovf), 1);
      check("b2b_full", int'(evt_bus.pend_cnt), DEPTH);

      // clear, then clear colliding with an overflow (set wins)
      step(0, tv, 1, 0);
      check("clr_ovf", int'(ovf), 0);
      tv = ~tv; step(0, tv, 1, 0);
      check("set_wins", int'(ovf), 1);
      step(0, tv, 1, 0);

      // toggle and accept together at full: no change, no overflow
      tv = ~tv; step(0, tv, 0, 1);
      check("simul_full", int'(evt_bus.pend_cnt), DEPTH);
      check("simul_noovf", int'(ovf), 0);
      for (int i = 0; i < 5; i++) step(0, tv, 0, 1);
      check("drained", int'(evt_bus.evt_valid), 0);

      // mid-stream reset with t_in changing across it
      tv = ~tv; step(0, tv, 0, 0);
      tv = ~tv; step(1, tv, 0, 0);
      check("rst_count", int'(evt_count), 0);
      step(0, tv, 0, 0);
      check("init_nopulse", int'(pulse_o), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, c, rdy;
         r   = ($urandom_range(63) == 0);
         c   = ($urandom_range(7) == 0);
         rdy = ($urandom_range(2) == 0);
         if ($urandom_range(1) == 1) tv = ~tv;
         step(r, tv, c, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
